elevator_monitor: RTL

ELEVATOR_MONITOR -- requirements
Module: elevator_monitor

---
 rtl/elevator_monitor_if.sv | 24 ++
 rtl/elevator_monitor.sv | 78 +++++++
 2 files changed

// File: rtl/elevator_monitor_if.sv
// elevator_monitor_if: observation bus between the elevator datapath and its run monitor.
interface elevator_monitor_if;
    logic [7:0] time_counter;
    logic [5:0] remaining_1, remaining_2, remaining_3, remaining_4;
    logic [5:0] remaining_5, remaining_6, remaining_7;
    logic [5:0] boarding_1, boarding_2;
    logic [2:0] curr_elevator_1, curr_elevator_2;
    logic       done, timeout, illegal_move;
    logic [7:0] finish_time, moves_1, moves_2;
    logic [1:0] mon_state;

    modport master (
        output time_counter, remaining_1, remaining_2, remaining_3, remaining_4,
               remaining_5, remaining_6, remaining_7, boarding_1, boarding_2,
               curr_elevator_1, curr_elevator_2,
        input  done, timeout, illegal_move, finish_time, moves_1, moves_2, mon_state
    );
    modport slave (
        input  time_counter, remaining_1, remaining_2, remaining_3, remaining_4,
               remaining_5, remaining_6, remaining_7, boarding_1, boarding_2,
               curr_elevator_1, curr_elevator_2,
        output done, timeout, illegal_move, finish_time, moves_1, moves_2, mon_state
    );
endinterface

// File: rtl/elevator_monitor.sv
// elevator_monitor: tracks one elevator run, counting moves and flagging completion or timeout.
module elevator_monitor #(
    parameter logic [7:0] TIMEOUT_LIMIT = 8'd200
) (
    input logic              clock,
    input logic              reset_start,
    elevator_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, TIMEOUT = 2'd3} state_t;

    state_t     r_state, w_state;
    logic       r_done, r_timeout, r_illegal, r_empty_q;
    logic [7:0] r_finish, r_cand, r_moves_1, r_moves_2;
    logic [2:0] r_prev_1, r_prev_2;
    logic       w_run, w_empty, w_jump_1, w_jump_2, w_complete, w_expire;

    assign w_run   = r_state == RUN;
    assign w_empty = ~|{bus.remaining_1, bus.remaining_2, bus.remaining_3, bus.remaining_4,
                        bus.remaining_5, bus.remaining_6, bus.remaining_7,
                        bus.boarding_1, bus.boarding_2};
    assign w_jump_1 = ((bus.curr_elevator_1 > r_prev_1) ? bus.curr_elevator_1 - r_prev_1
                                                        : r_prev_1 - bus.curr_elevator_1) > 3'd1;
    assign w_jump_2 = ((bus.curr_elevator_2 > r_prev_2) ? bus.curr_elevator_2 - r_prev_2
                                                        : r_prev_2 - bus.curr_elevator_2) > 3'd1;
    // completion outranks timeout when both qualify on the same edge
    assign w_complete = w_run && w_empty && r_empty_q;
    assign w_expire   = w_run && (bus.time_counter >= TIMEOUT_LIMIT) && !w_complete;

    always_comb begin
        w_state = (r_state == IDLE) ? RUN : w_complete ? DONE : w_expire ? TIMEOUT : r_state;
    end

    always_ff @(posedge clock) begin
        if (reset_start) r_state <= IDLE;
        else             r_state <= w_state;
    end

    always_ff @(posedge clock) begin
        if (reset_start) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_illegal <= 1'b0;
            r_empty_q <= 1'b0;
            r_finish  <= 8'd0;
            r_cand    <= 8'd0;
            r_moves_1 <= 8'd0;
            r_moves_2 <= 8'd0;
            r_prev_1  <= 3'd0;
            r_prev_2  <= 3'd0;
        end else if (r_state == IDLE) begin
            r_prev_1 <= bus.curr_elevator_1;
            r_prev_2 <= bus.curr_elevator_2;
        end else if (w_run) begin
            r_prev_1 <= bus.curr_elevator_1;
            r_prev_2 <= bus.curr_elevator_2;
            if (bus.curr_elevator_1 != r_prev_1 && r_moves_1 != 8'hff) r_moves_1 <= r_moves_1 + 8'd1;
            if (bus.curr_elevator_2 != r_prev_2 && r_moves_2 != 8'hff) r_moves_2 <= r_moves_2 + 8'd1;
            if (w_jump_1 || w_jump_2) r_illegal <= 1'b1;
            r_empty_q <= w_empty;
            if (w_empty && !r_empty_q) r_cand <= bus.time_counter;
            if (w_complete) begin
                r_done   <= 1'b1;
                r_finish <= r_cand;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
                r_finish  <= bus.time_counter;
            end
        end
    end

    assign bus.done         = r_done;
    assign bus.timeout      = r_timeout;
    assign bus.illegal_move = r_illegal;
    assign bus.finish_time  = r_finish;
    assign bus.moves_1      = r_moves_1;
    assign bus.moves_2      = r_moves_2;
    assign bus.mon_state    = r_state;
endmodule
